// File: rtl/moving_avg_filter.sv
// Block-oriented moving-average engine: accepts BLOCK_LEN samples per enable,
// emits one truncated 2^LOG2_TAPS-tap average per sample, then pulses filter_done.
module moving_avg_filter #(
    parameter int DATA_W    = 8,
    parameter int BLOCK_LEN = 16,
    parameter int LOG2_TAPS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              filter_enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    input  logic              result_ready,
    output logic              filter_done,
    output logic              busy
);

    localparam int HIST_N = (1 << LOG2_TAPS) - 1;
    localparam int SUM_W  = DATA_W + LOG2_TAPS;
    localparam int CNT_W  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [HIST_N-1:0][DATA_W-1:0]  hist_q, hist_d;
    logic                           result_valid_q, result_valid_d;
    logic [DATA_W-1:0]              result_data_q, result_data_d;
    logic                           accept;
    logic                           out_free;

    // Sum is widened by LOG2_TAPS bits so it can never wrap; the shift truncates.
    function automatic logic [DATA_W-1:0] tap_average(
        input logic [DATA_W-1:0]              x,
        input logic [HIST_N-1:0][DATA_W-1:0]  h
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(x);
        for (int i = 0; i < HIST_N; i++) begin
            sum = sum + SUM_W'(h[i]);
        end
        return DATA_W'(sum >> LOG2_TAPS);
    endfunction

    assign out_free     = !result_valid_q || result_ready;
    assign sample_ready = (state_q == S_RUN) && out_free;
    assign accept       = sample_valid && sample_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hist_d         = hist_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;

        case (state_q)
            S_IDLE: begin
                if (filter_enable) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                end
            end
            S_RUN: begin
                if (accept && (cnt_q == CNT_W'(BLOCK_LEN - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_free) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new result takes priority over the handshake that would empty the register.
        if (accept) begin
            result_valid_d = 1'b1;
            result_data_d  = tap_average(sample_data, hist_q);
            cnt_d          = cnt_q + CNT_W'(1);
            hist_d[0]      = sample_data;
            for (int i = 1; i < HIST_N; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end else if (result_valid_q && result_ready) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            hist_q         <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hist_q         <= hist_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
        end
    end

    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign filter_done  = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_moving_avg_filter.sv
// Scoreboard bench for moving_avg_filter: driver queues hand-computed results,
// a negedge monitor pops and compares on every result handshake.
module tb_moving_avg_filter;

    localparam logic [7:0] RAMP_EXP [16] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd14, 8'd18, 8'd22, 8'd26,
                                             8'd30, 8'd34, 8'd38, 8'd42, 8'd46, 8'd50, 8'd54, 8'd58};
    localparam logic [7:0] FULL_EXP [16] = '{8'd63, 8'd127, 8'd191, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
                                             8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};

    logic       clk = 1'b0;
    logic       reset;
    logic       filter_enable;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       sample_ready;
    logic       result_valid;
    logic [7:0] result_data;
    logic       result_ready;
    logic       filter_done;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_hs_cyc = -100;
    int         done_cnt = 0;
    int         done_cycs[$];
    logic [7:0] exp_q[$];

    moving_avg_filter #(.DATA_W(8), .BLOCK_LEN(16), .LOG2_TAPS(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .filter_enable(filter_enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_ready (result_ready),
        .filter_done  (filter_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every handshake consumes one queued expectation.
    always @(negedge clk) begin
        if (result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0d, expected no result (cycle %0d)", result_data, cyc);
            end else begin
                chk("result", int'(result_data), int'(exp_q.pop_front()));
            end
            last_hs_cyc = cyc;
        end
        if (filter_done) begin
            done_cnt++;
            done_cycs.push_back(cyc);
            chk("done_after_last_hs", cyc - last_hs_cyc, 1);
            chk("queue_empty_at_done", exp_q.size(), 0);
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] e);
        bit got;
        got = 1'b0;
        sample_valid = 1'b1;
        sample_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sample_ready) begin
                exp_q.push_back(e);
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic run_block(input bit full, input int drop_at, input bit bp);
        for (int i = 0; i < 16; i++) begin
            if (bp && i == 3) begin
                result_ready = 1'b0;
                sample_valid = 1'b1;
                sample_data  = 8'd16;
                for (int h = 0; h < 5; h++) begin
                    @(negedge clk);
                    chk("bp_sample_ready", int'(sample_ready), 0);
                    chk("bp_result_held", int'(result_data), 6);
                    @(posedge clk);
                    #1;
                end
                result_ready = 1'b1;
            end
            if (full) send(8'd255, FULL_EXP[i]);
            else      send(8'(4 * (i + 1)), RAMP_EXP[i]);
            if (i + 1 == drop_at) filter_enable = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (filter_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        int base;
        int gap;
        reset         = 1'b1;
        filter_enable = 1'b0;
        sample_valid  = 1'b0;
        sample_data   = '0;
        result_ready  = 1'b1;
        idle_cycles(3);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_result_data", int'(result_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sample_ready", int'(sample_ready), 0);
        chk("rst_filter_done", int'(filter_done), 0);
        reset = 1'b0;
        idle_cycles(2);
        chk("idle_sample_ready", int'(sample_ready), 0);

        // Ramp
        base = done_cnt;
        filter_enable = 1'b1;
        run_block(1'b0, 1, 1'b0);
        wait_done();
        idle_cycles(5);
        chk("ramp_done_count", done_cnt - base, 1);

        // Full scale
        base = done_cnt;
        filter_enable = 1'b1;
        run_block(1'b1, 1, 1'b0);
        wait_done();
        idle_cycles(5);
        chk("full_done_count", done_cnt - base, 1);

        // Backpressure
        base = done_cnt;
        filter_enable = 1'b1;
        run_block(1'b0, 1, 1'b1);
        wait_done();
        idle_cycles(5);
        chk("bp_done_count", done_cnt - base, 1);

        // Back-to-back blocks with enable held high
        base = done_cnt;
        filter_enable = 1'b1;
        run_block(1'b0, 0, 1'b0);
        run_block(1'b0, 0, 1'b0);
        wait_done();
        filter_enable = 1'b0;
        idle_cycles(5);
        chk("b2b_done_count", done_cnt - base, 2);
        if (done_cycs.size() >= 2) begin
            gap = done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2];
            if (gap < 18) chk("b2b_gap_at_least_18", gap, 18);
            else          chk("b2b_gap_at_least_18", 1, 1 - int'(gap < 18));
        end

        // Reset mid-block after the 7th accept
        base = done_cnt;
        filter_enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(8'(4 * (i + 1)), RAMP_EXP[i]);
        end
        reset = 1'b1;
        filter_enable = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_result_valid", int'(result_valid), 0);
        chk("midrst_sample_ready", int'(sample_ready), 0);
        chk("midrst_filter_done", int'(filter_done), 0);
        chk("midrst_queue_drained", exp_q.size(), 0);
        idle_cycles(1);
        reset = 1'b0;
        idle_cycles(3);
        chk("midrst_no_done", done_cnt - base, 0);
        filter_enable = 1'b1;
        run_block(1'b0, 1, 1'b0);
        wait_done();
        idle_cycles(5);
        chk("restart_done_count", done_cnt - base, 1);

        // Enable dropped after the 2nd accept
        base = done_cnt;
        filter_enable = 1'b1;
        run_block(1'b0, 2, 1'b0);
        wait_done();
        idle_cycles(6);
        chk("drop_done_count", done_cnt - base, 1);
        chk("drop_stays_idle", int'(busy), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "timeout");
    end

endmodule
